load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL expose parameter TIMEOUT, default 16, giving the maximum BUSY cycles to wait for mem_ack before aborting.
REQ-002 The block SHALL expose port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL expose port reset  in  1  synchronous, active-high reset.
REQ-004 The block SHALL expose port req_valid  in  1  core presents a memory operation.
REQ-005 The block SHALL expose port req_we  in  1  1=store, 0=load.
REQ-006 The block SHALL expose port req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-007 The block SHALL expose port req_addr  in  32  byte address from the ALU result.
REQ-008 The block SHALL expose port req_wdata  in  32  store data from register read port 2.
REQ-009 The block SHALL expose port req_ready  out  1  LSU can accept a request this cycle.
REQ-010 The block SHALL expose port stall  out  1  core must hold PC and suppress register writeback.
REQ-011 The block SHALL expose port rsp_valid  out  1  one-cycle completion pulse.
REQ-012 The block SHALL expose port rsp_rdata  out  32  extended load data.
REQ-013 The block SHALL expose port rsp_err  out  1  misaligned, illegal funct3, or timeout.
REQ-014 The block SHALL expose port mem_req  out  1  request to data memory.
REQ-015 The block SHALL expose port mem_we  out  1  memory write.
REQ-016 The block SHALL expose port mem_addr  out  32  word address: {addr[31:2],2'b00}.
REQ-017 The block SHALL expose port mem_wdata  out  32  lane-replicated store data.
REQ-018 The block SHALL expose port mem_be  out  4  byte enables.
REQ-019 The block SHALL expose port mem_rdata  in  32  memory read word.
REQ-020 The block SHALL expose port mem_ack  in  1  memory completion; valid only while mem_req=1.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1, latching we, funct3, addr and wdata.
REQ-023 On acceptance, an illegal funct3 SHALL set error, and SHALL go directly to RESP without asserting mem_req. Illegal funct3 is load 011/110/111 or store funct3 other than 000/001/010.
REQ-024 On acceptance, a misaligned access SHALL also set error and go directly to RESP without asserting mem_req. Misaligned is H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0.
REQ-025 For a legal access, the FSM SHALL go IDLE->BUSY; mem_req=1 and mem_we, mem_addr, mem_wdata, mem_be SHALL be held stable throughout BUSY.
REQ-026 In BUSY, mem_ack=1 SHALL capture the extended mem_rdata into rsp_rdata (loads) and transition to RESP.
REQ-027 A TIMEOUT-cycle counter SHALL run in BUSY; if mem_ack has not arrived after TIMEOUT BUSY cycles, the FSM SHALL drop mem_req, set error, and go to RESP.
REQ-028 In RESP, rsp_valid=1 for exactly one cycle, rsp_err reflects the error flag, and the next state is IDLE.
REQ-029 rsp_rdata SHALL be 0 for stores and errors, and SHALL hold its value until the next RESP.
REQ-030 Latency SHALL be as follows: accept at cycle N, ack at cycle M>=N+1 -> rsp_valid at M+1; error at acceptance -> rsp_valid at N+1.
REQ-031 mem_ack in IDLE or RESP SHALL be ignored.
REQ-032 mem_be SHALL be: SB/LB/LBU 4'b0001<<addr[1:0]; SH/LH/LHU addr[1]?4'b1100:4'b0011; SW/LW 4'b1111.
REQ-033 mem_wdata SHALL be: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-034 Load extraction SHALL select the byte at addr[1:0] or the half at addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-035 stall SHALL equal req_valid AND NOT rsp_valid (combinational), so the core advances only in the rsp_valid cycle.
REQ-036 Back-to-back operation SHALL be supported: a new request is accepted in the IDLE cycle following RESP.

Reset
REQ-037 On reset=1 at a clock edge, state SHALL be IDLE, and mem_req, rsp_valid, rsp_err, rsp_rdata and the timeout counter SHALL be 0, and req_ready SHALL be 1.
REQ-038 Reset during BUSY SHALL abandon the access (mem_req=0 the following cycle) and SHALL produce no rsp_valid.

Verification
REQ-039 The bench SHALL cover: LB addr 0x103, mem_rdata 0x80FF1234, ack 2 cycles after mem_req -> mem_be 4'b1000, rsp_rdata 0xFFFFFF80, rsp_valid 3 cycles after accept.
REQ-040 The bench SHALL cover: LHU addr 0x102, mem_rdata 0x8001ABCD, ack immediately -> rsp_rdata 0x00008001, rsp_err 0.
REQ-041 The bench SHALL cover: SH addr 0x202, wdata 0x1234BEEF -> mem_addr 0x200, mem_be 4'b1100, mem_wdata 0xBEEFBEEF, mem_we 1.
REQ-042 The bench SHALL cover: LW addr 0x101 -> no mem_req ever, rsp_valid+rsp_err one cycle after accept, rsp_rdata 0.
REQ-043 The bench SHALL cover: SW with mem_ack held 0, TIMEOUT=16 -> mem_req high exactly 16 cycles, then rsp_err=1.
REQ-044 The bench SHALL cover: reset asserted during BUSY -> mem_req 0 next cycle, no rsp_valid, req_ready 1.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding data-memory access at a time, with alignment/funct3
// checking, byte-lane steering, load extension and an ack timeout.
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_count;
   logic [2:0]      r_funct3;
   logic [1:0]      r_addrLo;
   logic            r_we;

   logic            w_illegal;
   logic            w_misaligned;
   logic [3:0]      w_be;
   logic [31:0]     w_wdata;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [31:0]     w_loadData;

   assign req_ready = (r_state == IDLE);
   assign stall     = req_valid & ~rsp_valid;

   // Request decode; funct3[1:0] gives the access size (byte/half/word) for all legal encodings.
   always_comb begin
      w_illegal    = req_we ? (req_funct3 > 3'b010)
                            : (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
      w_misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
      unique case (req_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << req_addr[1:0];
            w_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{req_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = req_wdata;
         end
      endcase
   end

   // Lane extraction and extension of the returned word for the latched load type.
   always_comb begin
      unique case (r_addrLo)
         2'd0:    w_byte = mem_rdata[7:0];
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      w_half = r_addrLo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      unique case (r_funct3)
         3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
         3'b100:  w_loadData = {24'd0, w_byte};
         3'b101:  w_loadData = {16'd0, w_half};
         default: w_loadData = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_funct3  <= '0;
         r_addrLo  <= '0;
         r_we      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_funct3 <= req_funct3;
                  r_addrLo <= req_addr[1:0];
                  r_we     <= req_we;
                  r_count  <= '0;
                  // Rejected requests never touch memory and respond on the next cycle.
                  if (w_illegal || w_misaligned) begin
                     r_state   <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     r_state   <= BUSY;
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= w_wdata;
                     mem_be    <= w_be;
                  end
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  r_state   <= RESP;
                  mem_req   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= r_we ? 32'd0 : w_loadData;
               end else if (r_count == CW'(TIMEOUT - 1)) begin
                  r_state   <= RESP;
                  mem_req   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
                  r_count <= r_count + CW'(1);
               end
            end
            RESP: begin
               r_state   <= IDLE;
               r_count   <= '0;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed corner cases plus randomized traffic, with a
// response scoreboard filled by the driver and drained by an independent monitor.
module tb_load_store_unit;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   int checks = 0;
   int errors = 0;
   int cycleCount = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          stamp;
   } exp_t;

   exp_t scoreQ[$];

   load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .stall      (stall),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycleCount);
      end
   endtask

   // Access rules expressed as size/offset arithmetic rather than per-encoding tables.
   function automatic void refModel(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] rdata,
                                    output logic err, output logic [3:0] be,
                                    output logic [31:0] wd, output logic [31:0] rd);
      int nb = 4;
      int off;
      bit sgn = 0;
      bit legal = 1;
      logic [31:0] shifted, mask, val;
      case (f3)
         3'd0: begin nb = 1; sgn = 1; end
         3'd1: begin nb = 2; sgn = 1; end
         3'd2: nb = 4;
         3'd4: begin nb = 1; legal = !we; end
         3'd5: begin nb = 2; legal = !we; end
         default: legal = 0;
      endcase
      off = int'(addr % 4);
      err = !legal || ((addr % nb) != 0);
      be  = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
      shifted = rdata >> (8 * off);
      if (nb == 4) val = shifted;
      else begin
         mask = (32'd1 << (8 * nb)) - 32'd1;
         val  = shifted & mask;
         if (sgn && val[8*nb-1]) val = val | ~mask;
      end
      rd = (we || err) ? 32'd0 : val;
   endfunction

   // Monitor: every completion pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && rsp_valid) begin
         if (scoreQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding (cycle %0d)", cycleCount + 1);
         end else begin
            e = scoreQ.pop_front();
            checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
            checkOutput("rsp_rdata", rsp_rdata, e.rdata);
            checkOutput("rsp_latency", 32'(cycleCount + 1), 32'(e.stamp));
         end
      end
   end

   // One core request; ackDelay=0 means memory never answers.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int ackDelay);
      logic expErr;
      logic [3:0] expBe;
      logic [31:0] expWd, expRd;
      int busyCount = 0;
      int w = 0;
      bit done = 0;
      exp_t e;
      refModel(we, f3, addr, wdata, rdata, expErr, expBe, expWd, expRd);
      while (!req_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      checkOutput("req_ready", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      mem_ack    = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      #1;
      checkOutput("stall_issue", 32'(stall), 32'd1);
      e.err   = expErr || (ackDelay == 0);
      e.rdata = (ackDelay == 0) ? 32'd0 : expRd;
      e.stamp = cycleCount + 1 + (expErr ? 1 : (ackDelay == 0 ? TIMEOUT + 1 : ackDelay + 1));
      scoreQ.push_back(e);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      for (int k = 0; k < TIMEOUT + 10 && !done; k++) begin
         if (rsp_valid) begin
            checkOutput("stall_resp", 32'(stall), 32'd0);
            done = 1;
         end else begin
            checkOutput("stall_wait", 32'(stall), 32'd1);
            if (expErr) checkOutput("mem_req_err", 32'(mem_req), 32'd0);
            else begin
               busyCount++;
               checkOutput("mem_req", 32'(mem_req), 32'd1);
               checkOutput("mem_addr", mem_addr, addr - (addr % 4));
               checkOutput("mem_be", 32'(mem_be), 32'(expBe));
               checkOutput("mem_wdata", mem_wdata, expWd);
               checkOutput("mem_we", 32'(mem_we), 32'(we));
               if (busyCount == ackDelay) begin
                  mem_ack   = 1'b1;
                  mem_rdata = rdata;
               end
            end
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL rsp_wait: no rsp_valid within %0d cycles of accept", TIMEOUT + 10);
      end
      if (!expErr && ackDelay == 0) checkOutput("timeout_busy_cycles", 32'(busyCount), 32'(TIMEOUT));
      req_valid = 1'b0;
      mem_ack   = 1'($urandom_range(0, 1));
   endtask

   // Idle gap with stray acks that the unit must ignore.
   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         mem_ack = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : driver
      int anyReq;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
      checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 2);
      applyStimulus(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_ABCD, 1);
      applyStimulus(1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'hDEAD_BEEF, 1);
      applyStimulus(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1111_1111, 1);
      applyStimulus(1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 0);
      applyStimulus(1'b1, 3'b011, 32'h0000_0400, 32'h5555_5555, 32'h0, 1);
      applyStimulus(1'b0, 3'b100, 32'h0000_0501, 32'h0, 32'h00C3_A500, 3);
      idleCycles(2);

      // Reset in the middle of an outstanding access.
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0600;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      checkOutput("busy_before_reset", 32'(mem_req), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("reset_busy_mem_req", 32'(mem_req), 32'd0);
      checkOutput("reset_busy_req_ready", 32'(req_ready), 32'd1);
      checkOutput("reset_busy_rsp_valid", 32'(rsp_valid), 32'd0);
      anyReq = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (mem_req || rsp_valid) anyReq++;
      end
      checkOutput("reset_busy_quiet", 32'(anyReq), 32'd0);

      for (int t = 0; t < 40; t++) begin
         int d;
         d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
         applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                       $urandom, $urandom, d);
         if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 3));
      end

      idleCycles(3);
      checkOutput("scoreboard_empty", 32'(scoreQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
